// File: rtl/dcache_fill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_fill_ctrl_pkg
// Purpose  : Shared widths, state encodings and helpers for the dcache fill
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_fill_ctrl_pkg;

    localparam logic [1:0] c_MEM_BYTE    = 2'd0;
    localparam logic [1:0] c_MEM_HALF    = 2'd1;
    localparam logic [1:0] c_MEM_WORD    = 2'd2;

    localparam int         c_RAM_ADDR_W  = 32;

    localparam logic [1:0] c_FC_IDLE     = 2'd0;
    localparam logic [1:0] c_FC_RD       = 2'd1;
    localparam logic [1:0] c_FC_WR       = 2'd2;
    localparam logic [1:0] c_FC_RFL      = 2'd3;

    typedef struct packed {
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
    } fill_req_t;

    function automatic logic is_sub_word(input logic [1:0] width);
        return (width == c_MEM_BYTE) || (width == c_MEM_HALF);
    endfunction

    // Index of the final byte written by a store of the given width.
    function automatic logic [2:0] last_byte_idx(input logic [1:0] width);
        logic [2:0] idx;
        case (width)
            c_MEM_BYTE: idx = 3'd0;
            c_MEM_HALF: idx = 3'd1;
            default:    idx = 3'd3;
        endcase
        return idx;
    endfunction

    // Unused encoding 3 is handled as a word access.
    function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                               input logic [1:0]  width);
        logic [31:0] a;
        case (width)
            c_MEM_BYTE: a = addr;
            c_MEM_HALF: a = {addr[31:1], 1'b0};
            default:    a = {addr[31:2], 2'b00};
        endcase
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_fill_ctrl_lane_sel.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_sel
// Purpose  : Extracts the byte/half/word lane addressed by addr[1:0] from a
//            32-bit word, right-aligned and zero-extended.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_sel
    import dcache_fill_ctrl_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_width,
    output logic [31:0] o_lane
);

    always_comb begin
        o_lane = i_word;
        case (i_width)
            c_MEM_BYTE: begin
                case (i_addr_lo)
                    2'd0:    o_lane = {24'd0, i_word[7:0]};
                    2'd1:    o_lane = {24'd0, i_word[15:8]};
                    2'd2:    o_lane = {24'd0, i_word[23:16]};
                    default: o_lane = {24'd0, i_word[31:24]};
                endcase
            end
            c_MEM_HALF: begin
                o_lane = i_addr_lo[1] ? {16'd0, i_word[31:16]}
                                      : {16'd0, i_word[15:0]};
            end
            default: o_lane = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dcache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_fill_ctrl
// Purpose  : Byte-serial RAM responder for MEM-stage loads/stores that keeps
//            the dcache coherent by refilling the whole aligned word.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_fill_ctrl
    import dcache_fill_ctrl_pkg::*;
#(
    parameter int RamAddrW = c_RAM_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [1:0]          width_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         wdata_i,
    output logic                done_o,
    output logic [31:0]         rdata_o,
    output logic                busy_o,
    input  logic [7:0]          mem_din_i,
    output logic [7:0]          mem_dout_o,
    output logic [RamAddrW-1:0] mem_a_o,
    output logic                mem_wr_o,
    output logic                cache_we_o,
    output logic [31:0]         cache_waddr_o,
    output logic [31:0]         cache_wdata_o
);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [2:0]  r_k;
    logic [2:0]  w_next_k;
    fill_req_t   r_req;
    logic [23:0] r_buf;
    logic [31:0] r_mem_a_last;

    logic [31:0] w_base;
    logic [31:0] w_word;
    logic [31:0] w_lane;
    logic        w_rd_end;
    logic        w_wr_last;
    logic        w_fire;
    logic        w_accept;

    logic [31:0] w_mem_a;
    logic [7:0]  w_mem_dout;
    logic        w_mem_wr;
    logic        w_cache_we;
    logic [31:0] w_cache_waddr;
    logic [31:0] w_cache_wdata;
    logic        w_done;
    logic [31:0] w_rdata;

    assign w_base    = {r_req.addr[31:2], 2'b00};
    assign w_word    = {mem_din_i, r_buf};
    assign w_rd_end  = (r_k == 3'd4);
    assign w_wr_last = (r_k == last_byte_idx(r_req.width));
    assign w_fire    = rdy && !rst;
    assign w_accept  = (r_state == c_FC_IDLE) && req_i && rdy;

    mem_lane_sel u_lane_sel (
        .i_word    (w_word),
        .i_addr_lo (r_req.addr[1:0]),
        .i_width   (r_req.width),
        .o_lane    (w_lane)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_FC_IDLE;
            r_k     <= 3'd0;
        end else if (rdy) begin
            r_state <= w_next_state;
            r_k     <= w_next_k;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_k     = r_k;
        case (r_state)
            c_FC_IDLE: begin
                if (req_i) begin
                    w_next_state = we_i ? c_FC_WR : c_FC_RD;
                    w_next_k     = 3'd0;
                end
            end
            c_FC_RD, c_FC_RFL: begin
                if (w_rd_end) begin
                    w_next_state = c_FC_IDLE;
                    w_next_k     = 3'd0;
                end else begin
                    w_next_k     = r_k + 3'd1;
                end
            end
            c_FC_WR: begin
                if (w_wr_last) begin
                    w_next_state = is_sub_word(r_req.width) ? c_FC_RFL : c_FC_IDLE;
                    w_next_k     = 3'd0;
                end else begin
                    w_next_k     = r_k + 3'd1;
                end
            end
            default: begin
                w_next_state = c_FC_IDLE;
                w_next_k     = 3'd0;
            end
        endcase
    end

    // The RAM returns data one cycle after its address, so during a stall the
    // previous address is replayed; the reissued cycle then sees the same
    // byte it would have seen without the stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req        <= '0;
            r_buf        <= 24'd0;
            r_mem_a_last <= 32'd0;
        end else begin
            r_mem_a_last <= w_mem_a;
            if (w_accept) begin
                r_req.width <= width_i;
                r_req.addr  <= align_addr(addr_i, width_i);
                r_req.wdata <= wdata_i;
            end
            if (rdy && ((r_state == c_FC_RD) || (r_state == c_FC_RFL))) begin
                case (r_k)
                    3'd1:    r_buf[7:0]   <= mem_din_i;
                    3'd2:    r_buf[15:8]  <= mem_din_i;
                    3'd3:    r_buf[23:16] <= mem_din_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_mem_a       = r_mem_a_last;
        w_mem_dout    = 8'd0;
        w_mem_wr      = 1'b0;
        w_cache_we    = 1'b0;
        w_cache_waddr = 32'd0;
        w_cache_wdata = 32'd0;
        w_done        = 1'b0;
        w_rdata       = 32'd0;
        case (r_state)
            c_FC_RD, c_FC_RFL: begin
                if (rdy && !w_rd_end) begin
                    w_mem_a = w_base + {29'd0, r_k};
                end
                if (w_rd_end && w_fire) begin
                    w_cache_we    = 1'b1;
                    w_cache_waddr = w_base;
                    w_cache_wdata = w_word;
                    w_done        = 1'b1;
                    w_rdata       = (r_state == c_FC_RD) ? w_lane : 32'd0;
                end
            end
            c_FC_WR: begin
                if (rdy) begin
                    w_mem_a = r_req.addr + {29'd0, r_k};
                end
                w_mem_dout = r_req.wdata[{r_k[1:0], 3'b000} +: 8];
                w_mem_wr   = w_fire;
                if (w_wr_last && !is_sub_word(r_req.width) && w_fire) begin
                    w_cache_we    = 1'b1;
                    w_cache_waddr = w_base;
                    w_cache_wdata = r_req.wdata;
                    w_done        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy_o        = (r_state != c_FC_IDLE);
    assign done_o        = w_done;
    assign rdata_o       = w_rdata;
    assign mem_a_o       = RamAddrW'(w_mem_a);
    assign mem_dout_o    = w_mem_dout;
    assign mem_wr_o      = w_mem_wr;
    assign cache_we_o    = w_cache_we;
    assign cache_waddr_o = w_cache_waddr;
    assign cache_wdata_o = w_cache_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dcache_fill_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for dcache_fill_ctrl: a byte RAM model feeds the DUT, a
// shadow memory predicts fills, load data, write traffic and completion time.
module tb_dcache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, req_i, we_i;
    logic [1:0]  width_i;
    logic [31:0] addr_i, wdata_i;
    logic        done_o, busy_o, mem_wr_o, cache_we_o;
    logic [31:0] rdata_o, mem_a_o, cache_waddr_o, cache_wdata_o;
    logic [7:0]  mem_din_i, mem_dout_o;

    dcache_fill_ctrl #(.RamAddrW(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req_i(req_i), .we_i(we_i),
        .width_i(width_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .done_o(done_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o), .mem_a_o(mem_a_o),
        .mem_wr_o(mem_wr_o), .cache_we_o(cache_we_o),
        .cache_waddr_o(cache_waddr_o), .cache_wdata_o(cache_wdata_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int cycle; logic [31:0] rdata; logic [31:0] waddr; logic [31:0] wdata; } exp_t;
    typedef struct { int cycle; logic [31:0] addr; logic [7:0] data; } wr_t;
    exp_t sbq[$];
    wr_t  wq[$];
    exp_t mon_e;
    wr_t  mon_w;

    logic [7:0] ram     [0:4095];
    logic [7:0] ref_mem [0:4095];
    logic       ram_init = 1'b1;

    function automatic logic [7:0] init_byte(int a);
        case (a)
            'h100:   return 8'h11;
            'h101:   return 8'h22;
            'h102:   return 8'h33;
            'h103:   return 8'h44;
            default: return 8'((a * 37 + 5) ^ (a >> 4));
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
            mem_din_i <= 8'd0;
        end else begin
            mem_din_i <= ram[mem_a_o[11:0]];
            if (mem_wr_o) ram[mem_a_o[11:0]] <= mem_dout_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", {31'd0, done_o}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("done_cycle", cyc, mon_e.cycle);
                chk("rdata", rdata_o, mon_e.rdata);
                chk("fill_we", {31'd0, cache_we_o}, 32'd1);
                chk("fill_addr", cache_waddr_o, mon_e.waddr);
                chk("fill_data", cache_wdata_o, mon_e.wdata);
            end
        end else if (cache_we_o !== 1'b0 || done_o !== 1'b0) begin
            chk("fill_without_done", {31'd0, cache_we_o}, 32'd0);
        end
        if (mem_wr_o === 1'b1) begin
            if (wq.size() == 0) begin
                chk("spurious_write", {31'd0, mem_wr_o}, 32'd0);
            end else begin
                mon_w = wq.pop_front();
                chk("wr_cycle", cyc, mon_w.cycle);
                chk("wr_addr", mem_a_o, mon_w.addr);
                chk("wr_data", {24'd0, mem_dout_o}, {24'd0, mon_w.data});
            end
        end else if (mem_wr_o !== 1'b0) begin
            chk("wr_strobe_x", {31'd0, mem_wr_o}, 32'd0);
        end
    end

    // Cycle of the i-th non-stalled cycle after acceptance at t.
    function automatic int slot_cycle(int t, logic [15:0] mask, int i);
        int c = t;
        int cnt = 0;
        while (cnt < i) begin
            c++;
            if ((c - t) > 15) cnt++;
            else if (!mask[c - t]) cnt++;
        end
        return c;
    endfunction

    function automatic logic [31:0] ref_word(logic [31:0] base);
        int b = int'(base & 32'hFFC);
        return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
    endfunction

    task automatic drive_req(input logic we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        req_i = 1'b1; we_i = we; width_i = w; addr_i = a; wdata_i = d;
    endtask

    task automatic txn(input logic we, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] d, input int pre, input logic [15:0] mask);
        int t, lat, n, off;
        logic [31:0] base, a0, word;
        exp_t e;
        wr_t  wr;
        for (int i = 0; i < pre; i++) begin
            @(posedge clk); #1;
            drive_req(we, w, a, d);
            rdy = 1'b0;
        end
        @(posedge clk); #1;
        drive_req(we, w, a, d);
        rdy = 1'b1;
        t = cyc;
        base = a & 32'hFFFF_FFFC;
        if (!we) begin
            lat  = 5;
            word = ref_word(base);
            case (w)
                2'd0:    e.rdata = (word >> (8 * (a % 4))) & 32'hFF;
                2'd1:    e.rdata = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
                default: e.rdata = word;
            endcase
        end else begin
            n  = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
            a0 = a & ~(n - 1);
            for (int j = 0; j < n; j++) begin
                ref_mem[int'((a0 + j) & 32'hFFF)] = d[8 * j +: 8];
                wr.cycle = slot_cycle(t, mask, j + 1);
                wr.addr  = a0 + j;
                wr.data  = d[8 * j +: 8];
                wq.push_back(wr);
            end
            lat     = (n == 4) ? 4 : n + 5;
            e.rdata = 32'd0;
        end
        e.cycle = slot_cycle(t, mask, lat);
        e.waddr = base;
        e.wdata = ref_word(base);
        sbq.push_back(e);
        while (cyc < e.cycle) begin
            @(posedge clk); #1;
            off = cyc - t;
            rdy = (off > 15) ? 1'b1 : !mask[off];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_i = 1'b0; rdy = 1'($urandom_range(0, 1));
            we_i = 1'($urandom); width_i = 2'($urandom_range(0, 2));
            addr_i = $urandom; wdata_i = $urandom;
        end
    endtask

    task automatic check_quiet(input string tag);
        #1;
        chk({tag, "_done"},   {31'd0, done_o},     32'd0);
        chk({tag, "_busy"},   {31'd0, busy_o},     32'd0);
        chk({tag, "_wr"},     {31'd0, mem_wr_o},   32'd0);
        chk({tag, "_fillwe"}, {31'd0, cache_we_o}, 32'd0);
        chk({tag, "_mem_a"},  mem_a_o,             32'd0);
        chk({tag, "_dout"},   {24'd0, mem_dout_o}, 32'd0);
        chk({tag, "_rdata"},  rdata_o,             32'd0);
        chk({tag, "_waddr"},  cache_waddr_o,       32'd0);
        chk({tag, "_wdata"},  cache_wdata_o,       32'd0);
    endtask

    initial begin
        logic [15:0] mask;
        logic [31:0] ra;
        rst = 1'b1; rdy = 1'b1; req_i = 1'b0; we_i = 1'b0;
        width_i = 2'd0; addr_i = 32'd0; wdata_i = 32'd0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(posedge clk);
        #1;
        ram_init = 1'b0;
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        txn(1'b0, 2'd2, 32'h100, 32'h0, 0, 16'h0);
        txn(1'b0, 2'd0, 32'h103, 32'h0, 0, 16'h0);
        idle(1);
        txn(1'b1, 2'd0, 32'h101, 32'hAB, 0, 16'h0);
        txn(1'b0, 2'd2, 32'h100, 32'h0, 1, 16'h0);
        idle(2);
        txn(1'b1, 2'd2, 32'h203, 32'hDEADBEEF, 0, 16'h0);
        txn(1'b0, 2'd2, 32'h200, 32'h0, 0, 16'h0018);
        idle(1);

        // Reset while a load is in flight: no fill, no done, quiet afterwards.
        @(posedge clk); #1;
        drive_req(1'b0, 2'd2, 32'h100, 32'h0);
        rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_quiet("post_rst");
        txn(1'b0, 2'd1, 32'h102, 32'h0, 0, 16'h0);
        txn(1'b1, 2'd1, 32'h10B, 32'h1234CAFE, 0, 16'h0);

        for (int k = 0; k < 200; k++) begin
            mask = 16'h0;
            for (int i = 1; i <= 10; i++) if ($urandom_range(0, 5) == 0) mask[i] = 1'b1;
            ra = ($urandom_range(0, 1) == 1) ? 32'h100 + $urandom_range(0, 31)
                                             : 32'($urandom_range(0, 4095));
            txn(1'($urandom), 2'($urandom_range(0, 2)), ra, $urandom,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0, mask);
            idle(int'($urandom_range(0, 2)));
        end

        idle(12);
        chk("sb_drained", sbq.size(), 32'd0);
        chk("wq_drained", wq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_fill_ctrl.md
# dcache_fill_ctrl

Memory-side responder for the MEM stage and the data cache. It serves load misses and all stores over the byte-wide RAM port. Every completed access writes the naturally aligned 32-bit word back into the dcache fill port (`we_i`/`waddr_i`/`wdata_i` of the cache), so cache lookups stay coherent with RAM. It sits between the MEM stage, the dcache, and the RAM arbiter.

## Interface
Parameters:
- `RamAddrW`, default 32: width of the RAM byte address.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high (`RstEnable` = 1'b1).
- `rdy`  in  1  global ready; low freezes the block.
- `req_i`  in  1  access request from MEM; held until `done_o`.
- `we_i`  in  1  1 = store, 0 = load.
- `width_i`  in  2  access width: `MemByte` = 0, `MemHalf` = 1, `MemWord` = 2.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data, right-aligned.
- `done_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  32  load data, right-aligned, zero-extended; valid only with `done_o`.
- `busy_o`  out  1  high in any state other than IDLE.
- `mem_din_i`  in  8  RAM read byte; valid one cycle after its address.
- `mem_dout_o`  out  8  RAM write byte.
- `mem_a_o`  out  RamAddrW  RAM byte address.
- `mem_wr_o`  out  1  RAM write strobe.
- `cache_we_o`  out  1  dcache fill strobe.
- `cache_waddr_o`  out  32  word-aligned fill address (bits [1:0] = 0).
- `cache_wdata_o`  out  32  fill word.

## Operation
- States: IDLE, RD, WR, RFL (refill after a sub-word store).
- IDLE transitions:
  - `req_i` with `we_i` = 0 goes to RD.
  - `we_i` = 1 with `MemWord` goes to WR.
  - `we_i` = 1 with a sub-word width goes to WR, then RFL.
- Request fields are latched on accept. Inputs are not re-sampled until IDLE.
- Alignment rules:
  - Word accesses ignore `addr_i[1:0]`.
  - Half accesses ignore `addr_i[0]`.
  - Base word = `{addr[31:2], 2'b00}`.
- RD and RFL, with a 3-bit counter k from 0 to 4:
  - For k = 0..3, `mem_a_o` = base + k.
  - Byte k-1 is captured from `mem_din_i`.
  - At k = 4 the word is assembled from bytes 0..2 and the live `mem_din_i` (byte 3).
- WR writes n bytes (1, 2, or 4) at the latched address + j, with `mem_dout_o` = `wdata[8j+7:8j]` and `mem_wr_o` = 1.
- Completion of a load:
  - `cache_we_o` = 1 with the assembled word.
  - `rdata_o` = the selected byte or half (lane chosen by the latched `addr[1:0]`), or the full word.
  - `done_o` = 1.
- Completion of a word store: on the last WR cycle, `cache_we_o` = 1 with `wdata`, and `done_o` = 1.
- Sub-word store: WR, then RFL re-reads the base word. It completes like a load, with `rdata_o` = 0.
- After completion the block returns to IDLE. `done_o` is never high for two consecutive cycles.
- `rdy` = 0:
  - State, counters and byte buffer hold.
  - `mem_wr_o`, `cache_we_o` and `done_o` are forced to 0.
  - The held cycle reissues when `rdy` returns.
- `rst` high:
  - Aborts any access immediately, with no cache fill and no partial `done_o`.
  - RAM bytes already written stay written.

## Timing
- Reset values: all outputs 0; state IDLE; k = 0.
- Request accepted at cycle T (IDLE, `req_i` = 1, `rdy` = 1).
- Load:
  - Addresses on T+1..T+4; bytes arrive T+2..T+5.
  - `done_o`/`cache_we_o` at T+5; IDLE at T+6. Latency is 5.
- Word store: writes T+1..T+4; `done_o` at T+4.
- Byte store: write T+1, refill addresses T+2..T+5, `done_o` at T+6.
- Half store: `done_o` at T+7.
- `mem_a_o` holds its last value when idle. `mem_wr_o` is 0 when idle.
- Handshake: the requester must drop or change `req_i` in the cycle after `done_o`. A `req_i` seen in IDLE is always a new request.
- Each `rdy`-low cycle stretches every latency by exactly one.

## Structure
- Add to `defines.v`:
  - `MemByte`/`MemHalf`/`MemWord`.
  - State encodings `FcIdle`/`FcRd`/`FcWr`/`FcRfl`.
  - `RamAddrBus`.
- One combinational sub-module, `mem_lane_sel`. It takes the word and `addr[1:0]` with the width, and returns the right-aligned zero-extended lane. It is instantiated once on the load path.

## Test plan
- Load word at 0x100 with RAM bytes 11 22 33 44:
  - `done_o` at T+5 with `rdata_o` = 0x44332211.
  - `cache_we_o` with waddr 0x100 and wdata 0x44332211.
- Load byte at 0x103, same RAM: `rdata_o` = 0x00000044, and the full word 0x44332211 is filled.
- Store byte 0xAB at 0x101, then load word 0x100:
  - Store: RAM write at 0x101 on T+1; `done_o` at T+6; cache fill 0x4433AB11.
  - Following load returns 0x4433AB11.
- Store word 0xDEADBEEF at 0x203 (misaligned): writes bytes EF BE AD DE at 0x200..0x203, with `cache_wdata_o` = 0xDEADBEEF at T+4.
- Drop `rdy` for 2 cycles mid-load, at k = 2:
  - `done_o` moves to T+7 with the correct word.
  - No extra `mem_wr_o` and no extra `cache_we_o`.
- Assert `rst` at T+3 of a load:
  - No `done_o` and no `cache_we_o`; outputs are 0 the next cycle.
  - A new request accepted afterward completes normally.
